datamem_arbiter: RTL

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between the Z80 core (cpu port) and the DMA engine (dma port). It registers the winning request and drives mem_addr/mem_din for a full setup cycle before raising mem_ce, so both are stable when the memory samples them on the ce rising edge. It holds them unchanged through the write clock edge, and returns read data with a one-cycle ack pulse.

---
 rtl/datamem_arbiter_if.sv | 55 +++++
 rtl/datamem_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/datamem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arbiter_if
// Brief    : Bundle of the cpu, dma and data-memory signals around the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface datamem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_wdata;
  logic              dma_ack;
  logic [7:0]        dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_ce;
  logic              mem_we;
  logic [7:0]        mem_dout;

  logic              busy;
  logic              grant_dma;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_addr, mem_din, mem_ce, mem_we,
    input  mem_dout,
    output busy, grant_dma
  );

  // Requesters plus memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_addr, mem_din, mem_ce, mem_we,
    output mem_dout,
    input  busy, grant_dma
  );
endinterface
`default_nettype wire

// File: rtl/datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arbiter
// Brief    : cpu/dma arbiter and setup-strobe-done sequencer for a 1-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module datamem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  datamem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic c_round_robin = (FIXED_PRIO == 0);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_din, w_din_nxt;
  logic              r_wr, w_wr_nxt;
  logic              r_grant, w_grant_nxt;
  logic              r_rr_dma, w_rr_nxt;
  logic              r_ce, w_ce_nxt;
  logic              r_we, w_we_nxt;
  logic              r_cpu_ack, w_cpu_ack_nxt;
  logic              r_dma_ack, w_dma_ack_nxt;
  logic [7:0]        r_cpu_rdata, w_cpu_rdata_nxt;
  logic [7:0]        r_dma_rdata, w_dma_rdata_nxt;
  logic              w_pick_dma;

  // r_rr_dma names the port that wins the next tie; it starts on the cpu.
  assign w_pick_dma = bus.dma_req & (~bus.cpu_req | (c_round_robin & r_rr_dma));

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_din_nxt       = r_din;
    w_wr_nxt        = r_wr;
    w_grant_nxt     = r_grant;
    w_rr_nxt        = r_rr_dma;
    w_ce_nxt        = 1'b0;
    w_we_nxt        = 1'b0;
    w_cpu_ack_nxt   = 1'b0;
    w_dma_ack_nxt   = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;
    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req | bus.dma_req) begin
          w_state_nxt = S_SETUP;
          w_grant_nxt = w_pick_dma;
          w_rr_nxt    = ~w_pick_dma;
          w_addr_nxt  = w_pick_dma ? bus.dma_addr  : bus.cpu_addr;
          w_din_nxt   = w_pick_dma ? bus.dma_wdata : bus.cpu_wdata;
          w_wr_nxt    = w_pick_dma ? bus.dma_we    : bus.cpu_we;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_STROBE;
        w_ce_nxt    = 1'b1;
        w_we_nxt    = r_wr;
      end
      S_STROBE: begin
        w_state_nxt   = S_DONE;
        w_cpu_ack_nxt = ~r_grant;
        w_dma_ack_nxt = r_grant;
        // Read data is valid while ce is high and is captured as ce falls.
        if (!r_wr) begin
          if (r_grant) w_dma_rdata_nxt = bus.mem_dout;
          else         w_cpu_rdata_nxt = bus.mem_dout;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_din       <= '0;
      r_wr        <= 1'b0;
      r_grant     <= 1'b0;
      r_rr_dma    <= 1'b0;
      r_ce        <= 1'b0;
      r_we        <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
      r_wr        <= w_wr_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_dma    <= w_rr_nxt;
      r_ce        <= w_ce_nxt;
      r_we        <= w_we_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_dma_ack   <= w_dma_ack_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_din   = r_din;
  assign bus.mem_ce    = r_ce;
  assign bus.mem_we    = r_we;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.grant_dma = r_grant;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
